// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared definitions for the instruction-memory boot loader:
//               FSM state encoding and byte-stream framing constants.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    // Loader FSM state encoding
    localparam logic [2:0] c_ST_HDR0  = 3'd0;
    localparam logic [2:0] c_ST_HDR1  = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_WRITE = 3'd3;
    localparam logic [2:0] c_ST_CHK   = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;
    localparam logic [2:0] c_ST_ERROR = 3'd6;

    // Stream framing: 2-byte big-endian word count, then 4 bytes per word
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Byte-stream boot loader. Receives a 16-bit big-endian word
//               count followed by big-endian 32-bit words, writes them to
//               instruction memory and releases the CPU hold when complete.
//               Optional trailing XOR checksum byte when
//               IMEM_LOADER_CHECKSUM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        restart,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    // Largest legal word count is the full memory depth
    localparam logic [16:0] c_MAX_WORDS = 17'd1 << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] c_ST_AFTER_LOAD = c_ST_CHK;
`else
    localparam logic [2:0] c_ST_AFTER_LOAD = c_ST_DONE;
`endif

    logic [2:0]      r_state;
    logic [15:0]     r_n;
    logic [ADDR_W:0] r_idx;
    logic [1:0]      r_bcnt;
    logic [23:0]     r_word;
    logic            r_imem_we;
    logic [31:0]     r_imem_addr;
    logic [31:0]     r_imem_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]      r_csum;
`endif

    logic            w_accept;
    logic [15:0]     w_n_full;
    logic            w_last_word;
    logic [31:0]     w_idx_addr;
    logic            w_word_full;

    assign w_accept    = in_valid & in_ready;
    assign w_n_full    = {r_n[15:8], in_data};
    assign w_last_word = (17'(r_idx) + 17'd1) == {1'b0, r_n};
    assign w_idx_addr  = 32'(r_idx) << 2;
    assign w_word_full = (r_bcnt == 2'(BYTES_PER_WORD - 1));

    // Output decode: handshake and status are pure functions of the state
    always_comb begin
        in_ready = (r_state == c_ST_HDR0) || (r_state == c_ST_HDR1) ||
                   (r_state == c_ST_DATA) || (r_state == c_ST_CHK);
        cpu_hold = (r_state != c_ST_DONE);
        done     = (r_state == c_ST_DONE);
        error    = (r_state == c_ST_ERROR);
    end

    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;

    // Loader FSM, word assembly and memory write port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= c_ST_HDR0;
            r_n          <= '0;
            r_idx        <= '0;
            r_bcnt       <= '0;
            r_word       <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            // Write strobe is a single-cycle pulse coinciding with WRITE
            r_imem_we <= 1'b0;
            case (r_state)
                c_ST_HDR0: begin
                    if (w_accept) begin
                        r_n[15:8] <= in_data;
                        r_state   <= c_ST_HDR1;
                    end
                end
                c_ST_HDR1: begin
                    if (w_accept) begin
                        r_n[7:0] <= in_data;
                        if ({1'b0, w_n_full} > c_MAX_WORDS) begin
                            r_state <= c_ST_ERROR;
                        end else if (w_n_full == 16'd0) begin
                            r_state <= c_ST_AFTER_LOAD;
                        end else begin
                            r_state <= c_ST_DATA;
                        end
                    end
                end
                c_ST_DATA: begin
                    if (w_accept) begin
                        r_word <= {r_word[15:0], in_data};
                        r_bcnt <= r_bcnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ in_data;
`endif
                        // Fourth byte completes the word: launch the write
                        if (w_word_full) begin
                            r_imem_we    <= 1'b1;
                            r_imem_addr  <= w_idx_addr;
                            r_imem_wdata <= {r_word, in_data};
                            r_state      <= c_ST_WRITE;
                        end
                    end
                end
                c_ST_WRITE: begin
                    r_idx   <= r_idx + {{ADDR_W{1'b0}}, 1'b1};
                    r_state <= w_last_word ? c_ST_AFTER_LOAD : c_ST_DATA;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                c_ST_CHK: begin
                    if (w_accept) begin
                        r_state <= (in_data == r_csum) ? c_ST_DONE : c_ST_ERROR;
                    end
                end
`endif
                c_ST_DONE, c_ST_ERROR: begin
                    if (restart) begin
                        r_state <= c_ST_HDR0;
                        r_n     <= '0;
                        r_idx   <= '0;
                        r_bcnt  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum  <= '0;
`endif
                    end
                end
                default: begin
                    r_state <= c_ST_HDR0;
                end
            endcase
        end
    end

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed self-checking bench for imem_loader. Follows the
//               IMEM_LOADER_CHECKSUM_EN setting of the build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        restart = 1'b0;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    imem_loader #(.ADDR_W(8)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .restart    (restart),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Log every memory write, sampled mid-cycle
    always @(negedge clk) begin
        if (reset && imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one byte and hold it until the loader takes it
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            check("in_ready_timeout", 32'd0, 32'd1);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    // Empty load; finishes in DONE
    task automatic empty_load();
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_we",       32'(imem_we),  32'd0);
        check("rst_addr",     imem_addr,     32'd0);
        check("rst_wdata",    imem_wdata,    32'd0);
        check("rst_hold",     32'(cpu_hold), 32'd1);
        check("rst_done",     32'(done),     32'd0);
        check("rst_error",    32'(error),    32'd0);
        reset = 1'b1;
        @(negedge clk);

        // ---------------- basic two-word load ----------------
        clear_log();
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h8C); send_byte(8'h09); send_byte(8'h00);
        send_byte(8'h04);
        check("basic_we_in_write", 32'(imem_we), 32'd1);
        check("basic_hold_in_write", 32'(cpu_hold), 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        @(negedge clk);
        check("basic_chk_ready", 32'(in_ready), 32'd1);
        check("basic_chk_notdone", 32'(done), 32'd0);
        send_byte(8'hAC);
`else
        @(negedge clk);
`endif
        check("basic_done", 32'(done), 32'd1);
        check("basic_hold", 32'(cpu_hold), 32'd0);
        check("basic_ready_done", 32'(in_ready), 32'd0);
        check("basic_we_idle", 32'(imem_we), 32'd0);
        check("basic_addr_held", imem_addr, 32'h4);
        check("basic_nwr", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check("basic_a0", wr_addr[0], 32'h0);
            check("basic_d0", wr_data[0], 32'h20080005);
            check("basic_a1", wr_addr[1], 32'h4);
            check("basic_d1", wr_data[1], 32'h8C090004);
        end
        do_restart();
        check("restart_done_clr", 32'(done), 32'd0);
        check("restart_hold", 32'(cpu_hold), 32'd1);
        check("restart_ready", 32'(in_ready), 32'd1);

        // ---------------- empty load ----------------
        clear_log();
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("empty_chk_ready", 32'(in_ready), 32'd1);
        send_byte(8'h00);
`endif
        check("empty_done", 32'(done), 32'd1);
        check("empty_hold", 32'(cpu_hold), 32'd0);
        check("empty_nwr", 32'(wr_addr.size()), 32'd0);
        do_restart();

        // ---------------- overflow: N = 257 ----------------
        clear_log();
        send_byte(8'h01);
        send_byte(8'h01);
        check("ovf_error", 32'(error), 32'd1);
        check("ovf_hold", 32'(cpu_hold), 32'd1);
        check("ovf_done", 32'(done), 32'd0);
        check("ovf_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        check("ovf_error_sticky", 32'(error), 32'd1);
        check("ovf_nwr", 32'(wr_addr.size()), 32'd0);
        do_restart();
        check("ovf_restart_clr", 32'(error), 32'd0);
        empty_load();
        check("ovf_recover_done", 32'(done), 32'd1);
        do_restart();

        // ---------------- backpressure, gaps, ignored restart ----------------
        clear_log();
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22);
        restart = 1'b1;                 // must be ignored in DATA
        @(negedge clk);
        restart = 1'b0;
        repeat (2) @(negedge clk);
        check("gap_ready", 32'(in_ready), 32'd1);
        send_byte(8'h33);
        send_byte(8'h44);
        in_valid = 1'b1;
        in_data  = 8'h55;
        check("bp_we", 32'(imem_we), 32'd1);
        check("bp_ready_write", 32'(in_ready), 32'd0);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
`ifdef IMEM_LOADER_CHECKSUM_EN
        @(negedge clk);
        send_byte(8'h88);
`else
        @(negedge clk);
`endif
        check("bp_done", 32'(done), 32'd1);
        check("bp_nwr", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check("bp_a0", wr_addr[0], 32'h0);
            check("bp_d0", wr_data[0], 32'h11223344);
            check("bp_a1", wr_addr[1], 32'h4);
            check("bp_d1", wr_data[1], 32'h55667788);
        end
        do_restart();

`ifdef IMEM_LOADER_CHECKSUM_EN
        // ---------------- checksum good / bad ----------------
        clear_log();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        @(negedge clk);
        send_byte(8'h08);
        check("csum_ok_done", 32'(done), 32'd1);
        check("csum_ok_err", 32'(error), 32'd0);
        check("csum_ok_nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            check("csum_ok_a0", wr_addr[0], 32'h0);
            check("csum_ok_d0", wr_data[0], 32'h12345678);
        end
        do_restart();
        clear_log();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        @(negedge clk);
        send_byte(8'h09);
        check("csum_bad_err", 32'(error), 32'd1);
        check("csum_bad_hold", 32'(cpu_hold), 32'd1);
        check("csum_bad_done", 32'(done), 32'd0);
        check("csum_bad_nwr", 32'(wr_addr.size()), 32'd1);
        do_restart();
`endif

        // ---------------- reset mid-word (N = 256 accepted) ----------------
        clear_log();
        send_byte(8'h01); send_byte(8'h00);
        check("n256_noerr", 32'(error), 32'd0);
        check("n256_ready", 32'(in_ready), 32'd1);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        #1;
        reset = 1'b0;
        #1;
        check("mid_we", 32'(imem_we), 32'd0);
        check("mid_addr", imem_addr, 32'd0);
        check("mid_wdata", imem_wdata, 32'd0);
        check("mid_hold", 32'(cpu_hold), 32'd1);
        check("mid_done", 32'(done), 32'd0);
        check("mid_error", 32'(error), 32'd0);
        check("mid_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_nwr", 32'(wr_addr.size()), 32'd0);
        empty_load();
        check("mid_recover_done", 32'(done), 32'd1);
        check("mid_recover_nwr", 32'(wr_addr.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_imem_loader
`default_nettype wire
